// File: rtl/or16_accum_pkg.sv
// Shared definitions for the OR-accumulating burst reducer.
// Holds the FSM state encoding, default word width and count width.
package or16_accum_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/or16_accum_or16.sv
// Plain bitwise OR gate used as the accumulation datapath.
module or16_accum_or16 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] out
);

  assign out = a | b;

endmodule

// File: rtl/or16_accum.sv
// Collects a burst of words, ORs them together and presents one result
// with the word count and a flag for bursts closed at MAX_WORDS.
module or16_accum
  import or16_accum_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_WORDS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_trunc,
  input  logic             out_ready
);

  // Handshake: a word transfers on a rising edge where in_valid && in_ready;
  // the result transfers on a rising edge where out_valid && out_ready.
  // Neither ready depends combinationally on the matching valid.

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] or_out;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             trunc;
  logic             accept;
  logic             done;

  or16_accum_or16 #(.W(WIDTH)) u_or (
    .a   (acc),
    .b   (in_data),
    .out (or_out)
  );

  // The first word of a burst loads directly so stale acc never leaks in.
  assign acc_next = (state == ST_IDLE) ? in_data : or_out;
  assign cnt_next = (state == ST_IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);

  assign done     = (state == ST_DONE);
  assign in_ready = ~reset & ~done;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
      trunc <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (accept) begin
            acc <= acc_next;
            cnt <= cnt_next;
            if (in_last) begin
              state <= ST_DONE;
              trunc <= 1'b0;
            end else if (cnt_next == CNT_W'(MAX_WORDS)) begin
              state <= ST_DONE;
              trunc <= 1'b1;
            end else begin
              state <= ST_ACCUM;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = done;
  assign out_data  = done ? acc : '0;
  assign out_count = done ? cnt : '0;
  assign out_trunc = done & trunc;

endmodule

// File: doc/or16_accum.md
OR16_ACCUM -- requirements
Module: or16_accum

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the data word width in bits.
REQ-002 The block SHALL have parameter MAX_WORDS, default 16, meaning the maximum number of words per burst (2..31).
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  meaning the reset: asynchronous, active-high.
REQ-005 The block SHALL have port in_valid  input  1  meaning the upstream word is present.
REQ-006 The block SHALL have port in_data  input  WIDTH  meaning the upstream word.
REQ-007 The block SHALL have port in_last  input  1  meaning the upstream word ends its burst.
REQ-008 The block SHALL have port in_ready  output  1  meaning the block accepts a word this cycle.
REQ-009 The block SHALL have port out_valid  output  1  meaning the result is present.
REQ-010 The block SHALL have port out_data  output  WIDTH  meaning the bitwise OR of all words in the burst.
REQ-011 The block SHALL have port out_count  output  5  meaning the number of words accepted in the burst.
REQ-012 The block SHALL have port out_trunc  output  1  meaning the burst was closed at MAX_WORDS without in_last.
REQ-013 The block SHALL have port out_ready  input  1  meaning downstream takes the result this cycle.

Function
REQ-014 A word SHALL be accepted only on a rising edge where in_valid and in_ready are both 1.
REQ-015 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-016 In IDLE: in_ready=1 and out_valid=0; an accepted word loads acc<=in_data and cnt<=1.
REQ-017 In ACCUM: in_ready=1 and out_valid=0; an accepted word updates acc<=acc|in_data and cnt<=cnt+1.
REQ-018 In IDLE or ACCUM, an accepted word with in_last=1 SHALL move the FSM to DONE with trunc<=0.
REQ-019 In IDLE or ACCUM, an accepted word that makes cnt==MAX_WORDS with in_last=0 SHALL move the FSM to DONE with trunc<=1.
REQ-020 Any other accepted word moves IDLE to ACCUM and keeps ACCUM in ACCUM.
REQ-021 When in_last=1 and cnt reaches MAX_WORDS on the same word, trunc SHALL be 0.
REQ-022 With no accepted word, state, acc and cnt SHALL hold.
REQ-023 In DONE: in_ready=0, out_valid=1, out_data=acc, out_count=cnt and out_trunc=trunc; these hold stable until out_ready=1.
REQ-024 In DONE, out_ready=1 SHALL move the FSM to IDLE on that edge; in_ready returns to 1 on the next cycle, with no bypass.
REQ-025 Latency SHALL be 1 cycle: out_valid rises on the cycle after the last word is accepted.
REQ-026 Throughput SHALL be one word per cycle within a burst, plus one DONE cycle minimum per burst.
REQ-027 After a truncated burst, further words SHALL start a new burst in IDLE.
REQ-028 In IDLE and ACCUM, out_data, out_count and out_trunc SHALL drive 0.
REQ-029 out_data SHALL equal the OR of exactly the accepted words, with no carries or width growth.
REQ-030 cnt SHALL be 5 bits and never exceed MAX_WORDS.

Reset
REQ-031 Asserting reset SHALL immediately force the FSM to IDLE and set acc=0, cnt=0 and trunc=0, independent of clk.
REQ-032 While reset is held, in_ready=0, out_valid=0, out_data=0, out_count=0 and out_trunc=0.
REQ-033 Reset during ACCUM or DONE SHALL discard the partial or pending result without emitting it.
REQ-034 The first word SHALL be accepted no earlier than the first rising edge after reset deasserts.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2), the WIDTH default and the count width of 5.
REQ-036 The OR datapath SHALL use one instance of the existing 16-bit OR gate module, with a=acc, b=in_data and out feeding acc.
REQ-037 The IDLE load SHALL bypass the OR instance through a mux.
REQ-038 All other logic SHALL reside in this module.

Verification
REQ-039 Single word 16'hAAAA with in_last=1, then out_ready=1 -> out_data=16'hAAAA, out_count=1, out_trunc=0, out_valid high for 1 cycle.
REQ-040 Burst 16'h3CC3, 16'h0FF0 (last), with out_ready held 0 for 3 cycles -> out_data=16'h3FF3 and out_count=2, stable, in_ready=0 throughout.
REQ-041 17 back-to-back words 16'h0001<<i (i=0..15), no in_last -> DONE with out_data=16'hFFFF, out_count=16, out_trunc=1; the 17th word is accepted only after release and forms a new burst.
REQ-042 Word 16 carries in_last=1 -> out_count=16, out_trunc=0.
REQ-043 Reset asserted mid-clock after 2 of 3 burst words (16'h1234, 16'h9876) -> outputs 0 immediately, no out_valid; a new burst 16'h5555 (last) -> out_data=16'h5555.
REQ-044 in_valid toggling 1/0 every cycle across a 4-word burst -> idle cycles hold state, and out_count=4.
